// File: rtl/determinante_nxn_seq_if.sv
// Element-load and start/busy/done handshake bundle for the NxN determinant engine.
interface determinante_nxn_seq_if #(
    parameter int N      = 5,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 48,
    parameter int IDX_W  = $clog2(N)
);
    logic                     wr_en;
    logic [IDX_W-1:0]         wr_row;
    logic [IDX_W-1:0]         wr_col;
    logic signed [DATA_W-1:0] wr_data;
    logic                     start;
    logic                     busy;
    logic                     done;
    logic                     singular;
    logic signed [ACC_W-1:0]  determinant;

    modport master (
        output wr_en, wr_row, wr_col, wr_data, start,
        input  busy, done, singular, determinant
    );

    modport slave (
        input  wr_en, wr_row, wr_col, wr_data, start,
        output busy, done, singular, determinant
    );
endinterface

// File: rtl/determinante_nxn_seq.sv
// Sequential NxN signed determinant: fraction-free Bareiss elimination with row pivoting,
// one product per cycle and a restoring divider for the exact divide by the previous pivot.
module determinante_nxn_seq #(
    parameter int N      = 5,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 48,
    parameter int IDX_W  = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    determinante_nxn_seq_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PIVOT  = 3'd1;
    localparam logic [2:0] SWAP   = 3'd2;
    localparam logic [2:0] ELIM   = 3'd3;
    localparam logic [2:0] DIV    = 3'd4;
    localparam logic [2:0] NEXT_K = 3'd5;
    localparam logic [2:0] FINAL  = 3'd6;

    localparam int               P_W      = 2 * ACC_W;
    localparam int               CNT_W    = $clog2(P_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(P_W - 1);
    localparam logic [IDX_W-1:0] LAST     = IDX_W'(N - 1);
    localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N);

    logic [2:0]              state;
    logic signed [ACC_W-1:0] a [N][N];
    logic [IDX_W-1:0]        k, i, j, r;
    logic signed [ACC_W-1:0] prev;
    logic                    sign_neg, zero;
    logic [P_W-1:0]          dq;
    logic [ACC_W-1:0]        rem, dvs;
    logic                    q_neg;
    logic [CNT_W-1:0]        cnt;
    logic                    busy, done, singular;
    logic signed [ACC_W-1:0] det;

    logic signed [DATA_W-1:0] wr_val;
    logic signed [P_W-1:0]    akk, aij, aik, akj, t;
    logic [P_W-1:0]           t_mag, dq_nxt;
    logic [ACC_W-1:0]         prev_mag, q_sgn;
    logic [ACC_W:0]           rem_sh, rem_diff;
    logic                     ge, last_elem, wr_hit;
    logic [IDX_W-1:0]         i_nxt, j_nxt;
    logic signed [ACC_W-1:0]  a_last, fin;

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.singular    = singular;
    assign bus.determinant = det;
    assign wr_val          = bus.wr_data;

    always_comb begin
        akk      = P_W'(a[k][k]);
        aij      = P_W'(a[i][j]);
        aik      = P_W'(a[i][k]);
        akj      = P_W'(a[k][j]);
        t        = akk * aij - aik * akj;
        t_mag    = t[P_W-1] ? -t : t;
        prev_mag = prev[ACC_W-1] ? -prev : prev;
        // rem < divisor always, so the borrow bit of the trial subtract is the compare result
        rem_sh   = {rem, dq[P_W-1]};
        rem_diff = rem_sh - {1'b0, dvs};
        ge       = ~rem_diff[ACC_W];
        dq_nxt   = {dq[P_W-2:0], ge};
        q_sgn    = q_neg ? -dq_nxt[ACC_W-1:0] : dq_nxt[ACC_W-1:0];
        last_elem = (i == LAST) && (j == LAST);
        i_nxt    = (j == LAST) ? i + 1'b1 : i;
        j_nxt    = (j == LAST) ? k + 1'b1 : j + 1'b1;
        a_last   = a[N-1][N-1];
        fin      = zero ? '0 : (sign_neg ? -a_last : a_last);
        wr_hit   = bus.wr_en && ({1'b0, bus.wr_row} < N_EXT) && ({1'b0, bus.wr_col} < N_EXT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            k        <= '0;
            i        <= '0;
            j        <= '0;
            r        <= '0;
            prev     <= ACC_W'(1);
            sign_neg <= 1'b0;
            zero     <= 1'b0;
            dq       <= '0;
            rem      <= '0;
            dvs      <= '0;
            q_neg    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            singular <= 1'b0;
            det      <= '0;
            for (int ri = 0; ri < N; ri++)
                for (int ci = 0; ci < N; ci++)
                    a[ri][ci] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_hit) a[bus.wr_row][bus.wr_col] <= ACC_W'(wr_val);
                    if (bus.start) begin
                        k        <= '0;
                        r        <= '0;
                        prev     <= ACC_W'(1);
                        sign_neg <= 1'b0;
                        zero     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= PIVOT;
                    end
                end
                // r starts at k, so the first probe is the diagonal itself
                PIVOT: begin
                    if (a[r][k] != '0) begin
                        i     <= k + 1'b1;
                        j     <= k + 1'b1;
                        state <= (r == k) ? ELIM : SWAP;
                    end else if (r == LAST) begin
                        zero  <= 1'b1;
                        state <= FINAL;
                    end else begin
                        r <= r + 1'b1;
                    end
                end
                SWAP: begin
                    for (int c = 0; c < N; c++) begin
                        a[k][c] <= a[r][c];
                        a[r][c] <= a[k][c];
                    end
                    sign_neg <= ~sign_neg;
                    state    <= ELIM;
                end
                ELIM: begin
                    if (k == '0) begin
                        a[i][j] <= t[ACC_W-1:0];
                        i       <= i_nxt;
                        j       <= j_nxt;
                        state   <= last_elem ? NEXT_K : ELIM;
                    end else begin
                        dq    <= t_mag;
                        rem   <= '0;
                        dvs   <= prev_mag;
                        q_neg <= t[P_W-1] ^ prev[ACC_W-1];
                        cnt   <= '0;
                        state <= DIV;
                    end
                end
                DIV: begin
                    rem <= ge ? rem_diff[ACC_W-1:0] : rem_sh[ACC_W-1:0];
                    dq  <= dq_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        a[i][j] <= q_sgn;
                        i       <= i_nxt;
                        j       <= j_nxt;
                        state   <= last_elem ? NEXT_K : ELIM;
                    end
                end
                NEXT_K: begin
                    prev  <= a[k][k];
                    k     <= k + 1'b1;
                    r     <= k + 1'b1;
                    state <= (k + 1'b1 == LAST) ? FINAL : PIVOT;
                end
                FINAL: begin
                    det      <= fin;
                    singular <= (fin == '0);
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_determinante_nxn_seq.sv
// Bench for determinante_nxn_seq: Leibniz-formula reference model, directed and random matrices.
module tb_determinante_nxn_seq;
    localparam int N      = 5;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 48;
    localparam int IDX_W  = $clog2(N);

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    determinante_nxn_seq_if #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .IDX_W(IDX_W)) bus();

    determinante_nxn_seq #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .IDX_W(IDX_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int     n_cmp = 0;
    int     n_bad = 0;
    int     mat [N][N];
    longint exp_det;
    bit     exp_sing, exp_known;
    longint held_det;
    bit     held_sing, held_valid, prev_done;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Determinant straight from the permutation-sum definition
    function automatic longint det_model();
        longint s, term;
        int     idx [N];
        int     tv, inv;
        bit     ok;
        s = 0;
        for (int p = 0; p < N**N; p++) begin
            tv = p; ok = 1; inv = 0; term = 1;
            for (int q = 0; q < N; q++) begin idx[q] = tv % N; tv = tv / N; end
            for (int x = 0; x < N; x++)
                for (int y = x + 1; y < N; y++) begin
                    if (idx[x] == idx[y]) ok = 0;
                    if (idx[x] > idx[y]) inv++;
                end
            if (ok) begin
                for (int q = 0; q < N; q++) term = term * longint'(mat[q][idx[q]]);
                s = (inv % 2 != 0) ? s - term : s + term;
            end
        end
        return s;
    endfunction

    // Output checker: result at every done pulse, held value on every idle cycle
    always @(negedge clk) begin
        if (!reset) begin
            held_det = 0; held_sing = 0; held_valid = 1; prev_done = 0;
        end else begin
            if (bus.done) begin
                chk("done_width", longint'(prev_done), 0);
                chk("busy_at_done", longint'(bus.busy), 0);
                if (exp_known) begin
                    chk("det", longint'(bus.determinant), exp_det);
                    chk("singular", longint'(bus.singular), longint'(exp_sing));
                    held_det = exp_det; held_sing = exp_sing; held_valid = 1;
                end else begin
                    held_valid = 0;
                end
            end else if (!bus.busy && held_valid) begin
                chk("det_hold", longint'(bus.determinant), held_det);
                chk("sing_hold", longint'(bus.singular), longint'(held_sing));
            end
            prev_done = bus.done;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_mat();
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mat[r][c] = 0;
    endtask

    task automatic ident();
        clear_mat();
        for (int d = 0; d < N; d++) mat[d][d] = 1;
    endtask

    task automatic load_mat();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                bus.wr_en = 1'b1; bus.wr_row = IDX_W'(r); bus.wr_col = IDX_W'(c);
                bus.wr_data = DATA_W'(mat[r][c]);
                tick();
            end
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (!bus.done && cyc < 4000) begin tick(); cyc++; end
        chk("done_seen", longint'(bus.done), 1);
        tick();
    endtask

    task automatic run(input bit known);
        exp_det = det_model(); exp_sing = (exp_det == 0); exp_known = known;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        wait_done();
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = '0; bus.start = 0;
        exp_known = 0; exp_det = 0; exp_sing = 0;
        repeat (3) tick();
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_done", longint'(bus.done), 0);
        chk("rst_det", longint'(bus.determinant), 0);
        chk("rst_sing", longint'(bus.singular), 0);
        reset = 1'b1;
        tick();

        // 1..25 row-major: rank 2, then restart without reload
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mat[r][c] = r * N + c + 1;
        chk("model_seq", det_model(), 0);
        load_mat(); run(1);
        run(0);

        ident();
        chk("model_ident", det_model(), 1);
        load_mat(); run(1);

        ident(); mat[0][0] = 0; mat[0][1] = 1; mat[1][0] = 1; mat[1][1] = 0;
        chk("model_swap", det_model(), -1);
        load_mat(); run(1);

        clear_mat();
        mat[0][0] = -2; mat[1][1] = 3; mat[2][2] = -1; mat[3][3] = 4; mat[4][4] = 2;
        chk("model_diag", det_model(), 48);
        load_mat(); run(1);

        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++)
            mat[r][c] = (r == c) ? -128 : ((c > r) ? 7 : 0);
        chk("model_utri", det_model(), -64'sd34359738368);
        load_mat(); run(1);

        // Cyclic row permutation: zero pivots at several k
        clear_mat();
        for (int r = 0; r < N; r++) mat[r][(r + 1) % N] = 1;
        chk("model_cycle", det_model(), 1);
        load_mat(); run(1);

        // Start and write while busy must be ignored
        clear_mat();
        for (int d = 0; d < N; d++) mat[d][d] = 127;
        chk("model_127", det_model(), 64'sd33038369407);
        load_mat();
        exp_det = det_model(); exp_sing = 0; exp_known = 1;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tick();
        bus.wr_en = 1'b1; bus.wr_row = 3'd4; bus.wr_col = 3'd4; bus.wr_data = 8'sd5; bus.start = 1'b1;
        tick();
        bus.wr_en = 1'b0; bus.start = 1'b0;
        wait_done();

        // Write and start in the same idle cycle
        ident(); load_mat();
        mat[4][4] = -3;
        bus.wr_en = 1'b1; bus.wr_row = 3'd4; bus.wr_col = 3'd4; bus.wr_data = -8'sd3;
        exp_det = det_model(); exp_sing = 0; exp_known = 1;
        bus.start = 1'b1; tick();
        bus.start = 1'b0; bus.wr_en = 1'b0;
        wait_done();

        // Reset in the middle of the divide phase
        ident(); load_mat();
        exp_known = 0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        repeat (60) tick();
        reset = 1'b0;
        #1;
        chk("midrst_busy", longint'(bus.busy), 0);
        chk("midrst_done", longint'(bus.done), 0);
        chk("midrst_det", longint'(bus.determinant), 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        clear_mat();
        run(1);
        ident(); mat[0][0] = 2; mat[0][1] = 1; mat[1][0] = 1; mat[1][1] = 3;
        chk("model_2x2", det_model(), 5);
        load_mat(); run(1);

        // Random sparse-ish matrices to provoke pivot scans and swaps
        for (int it = 0; it < 6; it++) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    mat[r][c] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
            load_mat(); run(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/determinante_nxn_seq.md
Name: determinante_nxn_seq

Overview:
- Parametrised successor of the fixed 5x5 determinant unit: sequential NxN signed-integer determinant engine using fraction-free Bareiss elimination with row pivoting.
- Matrix is loaded serially through an element write port; a start/busy/done handshake drives the computation.
- Sits behind the matrix-entry front end and feeds the result display path.

Parameters:
- N, 5, matrix dimension (2..8).
- DATA_W, 8, element width, two's-complement signed.
- ACC_W, 48, working/result width, signed; must hold every intermediate minor (N=5, DATA_W=8 needs ≥43).
- IDX_W, $clog2(N), row/column index width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  element write strobe; honoured only while busy=0.
- wr_row  in  IDX_W  row index of element.
- wr_col  in  IDX_W  column index of element.
- wr_data  in  DATA_W  signed element value, sign-extended to ACC_W on store.
- start  in  1  begin computation; honoured only while busy=0.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse when result is valid.
- singular  out  1  result is zero; valid with done.
- determinant  out  ACC_W  signed determinant.

Behaviour:
- Reset (reset=0, any time, including mid-computation): FSM→IDLE; busy, done, singular=0; determinant=0; matrix storage cleared to 0; prev=1; sign=+1.
- Indices ≥N on the write port: write ignored. wr_en and start in the same cycle: write lands first, then start is accepted. Both are ignored while busy=1.
- The working matrix is overwritten during computation. Contents are undefined after done; the host reloads all N*N elements before the next start.
- FSM states: IDLE, PIVOT, SWAP, ELIM, DIV, NEXT_K, FINAL.
- IDLE: on start, set k=0, prev=1, sign=+1; busy=1 next cycle; go to PIVOT.
- PIVOT: if a[k][k]≠0, go to ELIM. Otherwise scan rows r=k+1..N-1 one row per cycle for a[r][k]≠0.
  - Found: go to SWAP.
  - None found: go to FINAL with the zero flag set.
- SWAP: exchange rows k and r in one cycle; negate sign; go to ELIM.
- ELIM: for each (i,j) with i,j in k+1..N-1, row-major order, compute t = a[k][k]*a[i][j] − a[i][k]*a[k][j] at 2*ACC_W width.
  - If k=0 (prev=1), write a[i][j]=t truncated to ACC_W; one element per cycle.
  - Otherwise go to DIV.
- DIV: exact signed division t/prev via iterative restoring divider, 2*ACC_W cycles per element, on magnitudes with the sign corrected after. Write the quotient truncated to ACC_W, then return to ELIM for the next element.
- NEXT_K: after the last (i,j), set prev=a[k][k] and k=k+1. If k=N-1 go to FINAL, else go to PIVOT.
- FINAL: determinant = zero ? 0 : sign*a[N-1][N-1]; singular = (result==0). Assert done for exactly one cycle, drop busy in the same cycle, return to IDLE.
- determinant and singular hold until the next accepted start. They are not cleared by start; only reset clears them.
- Column k entries below the pivot are not rewritten; only i,j>k elements are consumed.
- Overflow beyond ACC_W is not detected; the parameter choice guarantees range.
- Latency is data-dependent. Worst case is bounded by N² pivot-scan cycles plus Σk (N−1−k)²·(2*ACC_W+1) plus 4N. The bench uses done, not cycle counts.

Test Plan:
- N=5, elements row-major 1..25, start → done, determinant=0, singular=1; a second start without reload is accepted and terminates with done.
- 5x5 identity → determinant=1, singular=0.
- Identity with rows 0 and 1 swapped (zero pivot at k=0) → SWAP exercised, determinant=−1.
- diag(−2,3,−1,4,2) → 48; upper-triangular with diagonal −128 and off-diagonals 7 → −34359738368; diagonal all 127 → 33038369407.
- Assert reset mid-DIV → busy, done, determinant=0 immediately. Reload [[2,1],[1,3]]-padded identity, start → determinant=5.
- Start and wr_en pulsed while busy → ignored, result unchanged. Start and wr_en in the same idle cycle → the written element is included in the result.
